inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Fetch stage directly upstream of the instruction memory/decode block.
- Generates the word-indexed PC that addresses instruction memory and captures the returned 32-bit instruction the same cycle.
- Buffers {pc, inst} pairs in a circular FIFO. Dispatch/reservation-station logic drains the FIFO under a valid/ready handshake.
- Supports full-queue flush and PC redirect for jumps and branch mispredicts.

Parameters:
- PC_WIDTH, 32: width of PC, imem_addr, redirect_pc and deq_pc.
- DEPTH, 4: number of queue entries; must be a power of 2, minimum 2.
- IMEM_WORDS, 64: instruction memory size in words; fetch halts once the PC reaches this value.
- RESET_PC, 0: PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  PC_WIDTH  word index to instruction memory; equals the fetch_pc register.
- imem_inst  in  32  instruction returned combinationally for imem_addr.
- redirect_valid  in  1  flush the queue and load redirect_pc.
- redirect_pc  in  PC_WIDTH  new word-indexed fetch PC.
- deq_valid  out  1  head entry available.
- deq_ready  in  1  consumer accepts the head entry this cycle.
- deq_inst  out  32  head instruction.
- deq_pc  out  PC_WIDTH  PC of the head instruction.
- count  out  log2(DEPTH)+1  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- fetch_done  out  1  fetch_pc >= IMEM_WORDS.

Behaviour:
- State:
  - fetch_pc register.
  - head and tail pointers, log2(DEPTH) bits each, wrapping modulo DEPTH.
  - count register.
  - entry arrays pc_q[DEPTH] and inst_q[DEPTH].
- Reset (rst=1 at an edge) overrides everything, including a redirect:
  - fetch_pc=RESET_PC; head=tail=0; count=0.
  - After reset: deq_valid=0, empty=1, full=0, fetch_done=0 (with default parameters).
  - Entry contents are don't-care.
- PC increments by 1 per fetched instruction; the PC is a word index, not a byte address.
- deq_valid = (count != 0) && !redirect_valid.
- deq_inst and deq_pc:
  - Combinational from inst_q[head] and pc_q[head] when count != 0.
  - Driven to 0 when empty.
- deq_fire = deq_valid && deq_ready.
- enq_fire = !redirect_valid && !fetch_done && (count < DEPTH || deq_fire).
  - A full queue accepts a new entry in the same cycle it dequeues; there is no combinational enqueue-to-dequeue bypass.
- On enq_fire:
  - pc_q[tail] <= fetch_pc; inst_q[tail] <= imem_inst.
  - tail <= tail+1; fetch_pc <= fetch_pc+1.
- On deq_fire: head <= head+1.
- count update:
  - +1 on enq only; -1 on deq only.
  - Unchanged when both or neither fire.
- Latency:
  - An instruction fetched at edge N is visible at the head no earlier than after edge N, i.e. 1 cycle.
  - Steady-state throughput is 1 instruction/cycle with deq_ready held high.
- Redirect (redirect_valid=1, rst=0):
  - head=tail=0; count=0; fetch_pc <= redirect_pc.
  - No enqueue and no dequeue that cycle.
  - Fetch of redirect_pc occurs in the following cycle.
  - Back-to-back redirects: the last one wins.
- fetch_done:
  - Combinational from fetch_pc.
  - While it is set, the queue keeps draining and no new entries are written.
  - Cleared only by a redirect into range or by reset.
- Pointer wrap: head and tail wrap DEPTH-1 -> 0 without gaps. full and empty come from count, never from pointer equality.
- deq_ready while empty has no effect. Outputs are glitch-free relative to registered state; no latches.

Test Plan:
- Memory model preloaded with [0]=0x20010064, [1]=0xAC010001, [2]=0x2020007B, [37]=0x0C000028, [38]=0x23190001.
- Hold deq_ready=0 after reset -> after 4 clocks count=4, full=1, imem_addr=4 held; deq_pc=0, deq_inst=0x20010064.
- From reset, deq_ready=1 throughout -> from cycle 2 on, one dequeue per cycle with deq_pc sequence 0,1,2 and deq_inst 0x20010064, 0xAC010001, 0x2020007B; count stays at most 1.
- Full queue (count=4), pulse deq_ready for 1 cycle -> count stays 4, head advances to pc=1, imem_addr increments by 1.
- count=3, redirect_valid=1 with redirect_pc=37 for 1 cycle with deq_ready=1:
  - That cycle: deq_valid=0, no head advance.
  - Next cycle: count=0, imem_addr=37.
  - Cycle after: deq_pc=37, deq_inst=0x0C000028; then pc=38, 0x23190001.
- Redirect to 62 with deq_ready=1 -> entries 62 and 63 are delivered, then fetch_done=1, imem_addr=64 held, queue drains to empty=1. A later redirect to 0 clears fetch_done.
- Assert rst for 1 cycle while count=3 and redirect_valid=1 -> next cycle count=0, imem_addr=RESET_PC=0, deq_valid=0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Fetch stage: drives the word-indexed PC to instruction memory and buffers
// {pc, inst} pairs in a circular FIFO drained by a valid/ready consumer.
module inst_fetch_queue #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic [31:0]               imem_inst,
    input  logic                      redirect_valid,
    input  logic [PC_WIDTH-1:0]       redirect_pc,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [31:0]               deq_inst,
    output logic [PC_WIDTH-1:0]       deq_pc,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      fetch_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PC_WIDTH-1:0] IMEM_END = PC_WIDTH'(IMEM_WORDS);
    localparam logic [PC_WIDTH-1:0] PC_INIT  = PC_WIDTH'(RESET_PC);
    localparam logic [PTR_W:0]      CNT_MAX  = (PTR_W+1)'(DEPTH);

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [PTR_W:0]      r_count;
    logic [PC_WIDTH-1:0] r_pc_q   [DEPTH];
    logic [31:0]         r_inst_q [DEPTH];

    logic w_fetch_done;
    logic w_nonempty;
    logic w_deq_valid;
    logic w_deq_fire;
    logic w_enq_fire;

    assign w_fetch_done = (r_fetch_pc >= IMEM_END);
    assign w_nonempty   = (r_count != '0);
    assign w_deq_valid  = w_nonempty && !redirect_valid;
    assign w_deq_fire   = w_deq_valid && deq_ready;
    // A full queue may still enqueue when the head leaves in the same cycle.
    assign w_enq_fire   = !redirect_valid && !w_fetch_done &&
                          ((r_count < CNT_MAX) || w_deq_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= PC_INIT;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_enq_fire) begin
                r_tail     <= r_tail + 1'b1;
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end
            if (w_deq_fire) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq_fire && !w_deq_fire) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq_fire && w_deq_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Entry storage carries no reset; contents are only observed when occupied.
    always_ff @(posedge clk) begin
        if (!rst && w_enq_fire) begin
            r_pc_q[r_tail]   <= r_fetch_pc;
            r_inst_q[r_tail] <= imem_inst;
        end
    end

    assign imem_addr  = r_fetch_pc;
    assign deq_valid  = w_deq_valid;
    assign deq_inst   = w_nonempty ? r_inst_q[r_head] : '0;
    assign deq_pc     = w_nonempty ? r_pc_q[r_head]   : '0;
    assign count      = r_count;
    assign full       = (r_count == CNT_MAX);
    assign empty      = !w_nonempty;
    assign fetch_done = w_fetch_done;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        fetch_done;

    logic [31:0] mem [64];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;

    int n_checks = 0;
    int n_pass   = 0;

    inst_fetch_queue #(
        .PC_WIDTH  (32),
        .DEPTH     (4),
        .IMEM_WORDS(64),
        .RESET_PC  (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_inst     (imem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .deq_valid     (deq_valid),
        .deq_ready     (deq_ready),
        .deq_inst      (deq_inst),
        .deq_pc        (deq_pc),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .fetch_done    (fetch_done)
    );

    assign imem_inst = (imem_addr < 32'd64) ? mem[imem_addr[5:0]] : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain queue of fetched entries plus a fetch PC.
    function automatic void model_edge();
        logic d_fire;
        logic e_fire;
        if (rst) begin
            mq.delete();
            m_pc = 32'd0;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc;
        end else begin
            d_fire = (mq.size() != 0) && deq_ready;
            e_fire = (m_pc < 32'd64) && ((mq.size() < 4) || d_fire);
            if (d_fire) void'(mq.pop_front());
            if (e_fire) begin
                mq.push_back('{pc: m_pc, inst: mem[m_pc[5:0]]});
                m_pc = m_pc + 32'd1;
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (deq_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || fetch_done !== 1'b0
            || count !== 3'd0 || imem_addr !== 32'd0)
            $display("FAIL reset: valid=%b empty=%b full=%b done=%b count=%0d addr=%0d, need 0 1 0 0 0 0",
                     deq_valid, empty, full, fetch_done, count, imem_addr);
        else n_pass++;
    endtask

    task automatic test_fill();
        deq_ready = 1'b0;
        repeat (4) cyc();
        #1;
        n_checks++;
        if (count !== 3'd4 || full !== 1'b1 || imem_addr !== 32'd4)
            $display("FAIL fill_state: count=%0d full=%b addr=%0d, need 4 1 4", count, full, imem_addr);
        else n_pass++;
        n_checks++;
        if (deq_pc !== 32'd0 || deq_inst !== 32'h20010064)
            $display("FAIL fill_head: pc=%0d inst=%h, need 0 20010064", deq_pc, deq_inst);
        else n_pass++;
        cyc();
        #1;
        n_checks++;
        if (imem_addr !== 32'd4 || count !== 3'd4)
            $display("FAIL fill_hold: addr=%0d count=%0d, need 4 4", imem_addr, count);
        else n_pass++;
    endtask

    task automatic test_full_pulse();
        deq_ready = 1'b1;
        #1;
        n_checks++;
        if (deq_valid !== 1'b1)
            $display("FAIL pulse_valid: got %b need 1", deq_valid);
        else n_pass++;
        cyc();
        deq_ready = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd4 || deq_pc !== 32'd1 || deq_inst !== 32'hAC010001 || imem_addr !== 32'd5)
            $display("FAIL full_pulse: count=%0d pc=%0d inst=%h addr=%0d, need 4 1 ac010001 5",
                     count, deq_pc, deq_inst, imem_addr);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_inst [3];
        exp_inst[0] = 32'h20010064; exp_inst[1] = 32'hAC010001; exp_inst[2] = 32'h2020007B;
        do_reset();
        deq_ready = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (deq_valid !== 1'b1 || deq_pc !== 32'(i) || deq_inst !== exp_inst[i] || count > 3'd1)
                $display("FAIL stream[%0d]: valid=%b pc=%0d inst=%h count=%0d, need 1 %0d %h <=1",
                         i, deq_valid, deq_pc, deq_inst, count, i, exp_inst[i]);
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) cyc();
        redirect_valid = 1'b1; redirect_pc = 32'd37; deq_ready = 1'b1;
        #1;
        n_checks++;
        if (count !== 3'd3 || deq_valid !== 1'b0)
            $display("FAIL redir_cycle: count=%0d valid=%b, need 3 0", count, deq_valid);
        else n_pass++;
        cyc();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || imem_addr !== 32'd37 || deq_valid !== 1'b0)
            $display("FAIL redir_next: count=%0d addr=%0d valid=%b, need 0 37 0", count, imem_addr, deq_valid);
        else n_pass++;
        cyc();
        #1;
        n_checks++;
        if (deq_pc !== 32'd37 || deq_inst !== 32'h0C000028 || deq_valid !== 1'b1)
            $display("FAIL redir_head37: pc=%0d inst=%h valid=%b, need 37 0c000028 1", deq_pc, deq_inst, deq_valid);
        else n_pass++;
        cyc();
        #1;
        n_checks++;
        if (deq_pc !== 32'd38 || deq_inst !== 32'h23190001)
            $display("FAIL redir_head38: pc=%0d inst=%h, need 38 23190001", deq_pc, deq_inst);
        else n_pass++;
    endtask

    task automatic test_end_of_mem();
        redirect_valid = 1'b1; redirect_pc = 32'd62; deq_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        for (int i = 62; i < 64; i++) begin
            #1;
            n_checks++;
            if (deq_valid !== 1'b1 || deq_pc !== 32'(i) || deq_inst !== mem[i])
                $display("FAIL eom_head[%0d]: valid=%b pc=%0d inst=%h, need 1 %0d %h",
                         i, deq_valid, deq_pc, deq_inst, i, mem[i]);
            else n_pass++;
            cyc();
        end
        cyc();
        #1;
        n_checks++;
        if (fetch_done !== 1'b1 || imem_addr !== 32'd64 || empty !== 1'b1 || deq_valid !== 1'b0)
            $display("FAIL eom_done: done=%b addr=%0d empty=%b valid=%b, need 1 64 1 0",
                     fetch_done, imem_addr, empty, deq_valid);
        else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        cyc();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (fetch_done !== 1'b0 || imem_addr !== 32'd0)
            $display("FAIL eom_clear: done=%b addr=%0d, need 0 0", fetch_done, imem_addr);
        else n_pass++;
    endtask

    task automatic test_reset_over_redirect();
        do_reset();
        repeat (3) cyc();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd37;
        cyc();
        rst = 1'b0; redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || imem_addr !== 32'd0 || deq_valid !== 1'b0)
            $display("FAIL rst_over_redir: count=%0d addr=%0d valid=%b, need 0 0 0", count, imem_addr, deq_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_valid;
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            redirect_valid = ($urandom_range(0, 14) == 0);
            redirect_pc    = 32'($urandom_range(0, 70));
            deq_ready      = ($urandom_range(0, 3) != 0);
            #1;
            e_valid = (mq.size() != 0) && !redirect_valid;
            e_pc    = (mq.size() != 0) ? mq[0].pc   : 32'd0;
            e_inst  = (mq.size() != 0) ? mq[0].inst : 32'd0;
            n_checks++;
            if (deq_valid !== e_valid || deq_pc !== e_pc || deq_inst !== e_inst
                || count !== 3'(mq.size()) || full !== (mq.size() == 4) || empty !== (mq.size() == 0)
                || imem_addr !== m_pc || fetch_done !== (m_pc >= 32'd64))
                $display("FAIL random[%0d]: valid=%b pc=%0d inst=%h count=%0d addr=%0d done=%b, need %b %0d %h %0d %0d %b",
                         i, deq_valid, deq_pc, deq_inst, count, imem_addr, fetch_done,
                         e_valid, e_pc, e_inst, mq.size(), m_pc, (m_pc >= 32'd64));
            else n_pass++;
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h20010064; mem[1] = 32'hAC010001; mem[2] = 32'h2020007B;
        mem[37] = 32'h0C000028; mem[38] = 32'h23190001;
        mq.delete();
        m_pc = 32'd0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_full_pulse();
        test_stream();
        test_redirect();
        test_end_of_mem();
        test_reset_over_redirect();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
